// File: rtl/spi_bus_ctrl.sv
// SPI slave to peripheral-bus sequencer: synchronizes SPI strobes, decodes the command byte,
// and arbitrates the shared register bus between SPI traffic and a local requester.
module spi_bus_ctrl #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSPI_SS_n,
    input  logic              iSPI_WRITE_SIG,
    input  logic              iSPI_READ_SIG,
    input  logic              iSPI_INC_WRADDR,
    input  logic              iSPI_INC_RDADDR,
    input  logic [7:0]        iSPI_RCV_BYTE,
    input  logic [7:0]        iSPI_RCV_CMD,
    output logic [7:0]        oSPI_SEND_BYTE,
    output logic              oSPI_ACTIVE,
    output logic              oOVERRUN,
    input  logic              iLOC_REQ,
    input  logic              iLOC_WE,
    input  logic [3:0]        iLOC_SEL,
    input  logic [ADDR_W-1:0] iLOC_ADDR,
    input  logic [7:0]        iLOC_WDATA,
    output logic              oLOC_GNT,
    output logic              oLOC_DONE,
    output logic [7:0]        oLOC_RDATA,
    output logic [3:0]        oBUS_SEL,
    output logic [ADDR_W-1:0] oBUS_ADDR,
    output logic              oBUS_WE,
    output logic              oBUS_RE,
    output logic [7:0]        oBUS_WDATA,
    input  logic [7:0]        iBUS_RDATA,
    input  logic              iBUS_ACK
);

    localparam int unsigned N_SYNC = 5;
    localparam int unsigned I_SS   = 4;
    localparam int unsigned I_WR   = 3;
    localparam int unsigned I_RD   = 2;
    localparam int unsigned I_IW   = 1;
    localparam int unsigned I_IR   = 0;
    // SS idles high, so its synchronizer resets high to avoid a false edge out of reset
    localparam logic [N_SYNC-1:0] SYNC_RST = 5'b10000;

    typedef enum logic [1:0] {ST_IDLE, ST_SPI_WR, ST_SPI_RD, ST_LOC} state_t;

    logic [N_SYNC-1:0] w_lvl;
    logic [N_SYNC-1:0] r_sync1;
    logic [N_SYNC-1:0] r_sync2;
    logic [N_SYNC-1:0] r_sync3;
    logic [N_SYNC-1:0] w_rise;
    logic              w_ss_fall;
    logic              w_ss_rise;

    logic              r_active;
    logic [1:0]        r_rd_cnt;
    logic              r_dir;
    logic [3:0]        r_sel;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [7:0]        r_wdata;
    logic              r_wr_pend;
    logic              r_rd_pend;
    logic              r_overrun;

    logic              w_live;
    logic              w_decode;
    logic              w_wr_req;
    logic              w_rd_req;
    logic              w_inc_wr;
    logic              w_inc_rd;
    logic              w_ack;
    logic              w_wr_clr;
    logic              w_rd_clr;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_bus_sel,   w_bus_sel_nxt;
    logic [ADDR_W-1:0] r_bus_addr,  w_bus_addr_nxt;
    logic [7:0]        r_bus_wdata, w_bus_wdata_nxt;
    logic              r_bus_we,    w_bus_we_nxt;
    logic              r_bus_re,    w_bus_re_nxt;
    logic              r_loc_gnt,   w_loc_gnt_nxt;
    logic              r_loc_done,  w_loc_done_nxt;
    logic [7:0]        r_loc_rdata, w_loc_rdata_nxt;
    logic              r_loc_we,    w_loc_we_nxt;
    logic [7:0]        r_send_byte, w_send_byte_nxt;

    // Two-flop synchronizers plus one edge-detect stage for all SPI-domain levels
    assign w_lvl = {iSPI_SS_n, iSPI_WRITE_SIG, iSPI_READ_SIG, iSPI_INC_WRADDR, iSPI_INC_RDADDR};

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_sync1 <= SYNC_RST;
            r_sync2 <= SYNC_RST;
            r_sync3 <= SYNC_RST;
        end else begin
            r_sync1 <= w_lvl;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise    = r_sync2 & ~r_sync3;
    assign w_ss_fall = ~r_sync2[I_SS] & r_sync3[I_SS];
    assign w_ss_rise = w_rise[I_SS];

    // SS rising in the same cycle suppresses any new request; decode owns its cycle
    assign w_live   = r_active & ~w_ss_rise;
    assign w_decode = w_live & w_rise[I_RD] & (r_rd_cnt == 2'd1);
    assign w_rd_req = w_live & ((w_decode & ~iSPI_RCV_CMD[7]) |
                                (w_rise[I_RD] & (r_rd_cnt == 2'd2) & ~r_dir));
    assign w_wr_req = w_live & w_rise[I_WR] & (r_rd_cnt == 2'd2) & r_dir;
    assign w_inc_wr = w_live & w_rise[I_IW] & (r_rd_cnt == 2'd2) & r_dir;
    assign w_inc_rd = w_live & w_rise[I_IR] & (r_rd_cnt == 2'd2) & ~r_dir;

    assign w_ack    = iBUS_ACK & (r_bus_we | r_bus_re);
    assign w_wr_clr = (r_state == ST_SPI_WR) & w_ack;
    assign w_rd_clr = (r_state == ST_SPI_RD) & w_ack;

    // Per-transaction command, address counters, pending flags and overrun
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_active  <= 1'b0;
            r_rd_cnt  <= 2'd0;
            r_dir     <= 1'b0;
            r_sel     <= 4'd0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_wdata   <= 8'd0;
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_ss_fall) begin
            r_active  <= 1'b1;
            r_rd_cnt  <= 2'd0;
            r_dir     <= 1'b0;
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_ss_rise) begin
                r_active <= 1'b0;
            end
            if (w_wr_clr || (w_ss_rise && r_state != ST_SPI_WR)) begin
                r_wr_pend <= 1'b0;
            end
            if (w_rd_clr || (w_ss_rise && r_state != ST_SPI_RD)) begin
                r_rd_pend <= 1'b0;
            end
            if (w_live && w_rise[I_RD] && r_rd_cnt != 2'd2) begin
                r_rd_cnt <= r_rd_cnt + 2'd1;
            end
            if (w_decode) begin
                r_dir     <= iSPI_RCV_CMD[7];
                r_sel     <= iSPI_RCV_CMD[6:3];
                r_wr_addr <= ADDR_W'(iSPI_RCV_CMD[2:0]);
                r_rd_addr <= ADDR_W'(iSPI_RCV_CMD[2:0]);
            end
            if (w_inc_wr) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
            if (w_inc_rd) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
            if (w_wr_req) begin
                if (r_wr_pend && !w_wr_clr) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_wr_pend <= 1'b1;
                    r_wdata   <= iSPI_RCV_BYTE;
                end
            end
            if (w_rd_req) begin
                if (r_rd_pend && !w_rd_clr) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_rd_pend <= 1'b1;
                end
            end
        end
    end

    // Arbiter state and registered bus/local outputs
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state     <= ST_IDLE;
            r_bus_sel   <= 4'd0;
            r_bus_addr  <= '0;
            r_bus_wdata <= 8'd0;
            r_bus_we    <= 1'b0;
            r_bus_re    <= 1'b0;
            r_loc_gnt   <= 1'b0;
            r_loc_done  <= 1'b0;
            r_loc_rdata <= 8'd0;
            r_loc_we    <= 1'b0;
            r_send_byte <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_sel   <= w_bus_sel_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_re    <= w_bus_re_nxt;
            r_loc_gnt   <= w_loc_gnt_nxt;
            r_loc_done  <= w_loc_done_nxt;
            r_loc_rdata <= w_loc_rdata_nxt;
            r_loc_we    <= w_loc_we_nxt;
            r_send_byte <= w_send_byte_nxt;
        end
    end

    // Bus fields are latched on leaving IDLE so counter updates cannot disturb an access
    always_comb begin
        w_state_nxt     = r_state;
        w_bus_sel_nxt   = r_bus_sel;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_bus_we_nxt    = 1'b0;
        w_bus_re_nxt    = 1'b0;
        w_loc_gnt_nxt   = r_loc_gnt;
        w_loc_done_nxt  = 1'b0;
        w_loc_rdata_nxt = r_loc_rdata;
        w_loc_we_nxt    = r_loc_we;
        w_send_byte_nxt = r_send_byte;
        case (r_state)
            ST_IDLE: begin
                w_bus_sel_nxt   = 4'd0;
                w_bus_addr_nxt  = '0;
                w_bus_wdata_nxt = 8'd0;
                w_loc_gnt_nxt   = 1'b0;
                if (r_wr_pend && !w_ss_rise) begin
                    w_state_nxt     = ST_SPI_WR;
                    w_bus_sel_nxt   = r_sel;
                    w_bus_addr_nxt  = r_wr_addr;
                    w_bus_wdata_nxt = r_wdata;
                end else if (r_rd_pend && !w_ss_rise) begin
                    w_state_nxt    = ST_SPI_RD;
                    w_bus_sel_nxt  = r_sel;
                    w_bus_addr_nxt = r_rd_addr;
                end else if (iLOC_REQ) begin
                    w_state_nxt     = ST_LOC;
                    w_bus_sel_nxt   = iLOC_SEL;
                    w_bus_addr_nxt  = iLOC_ADDR;
                    w_bus_wdata_nxt = iLOC_WE ? iLOC_WDATA : 8'd0;
                    w_loc_we_nxt    = iLOC_WE;
                    w_loc_gnt_nxt   = 1'b1;
                end
            end
            ST_SPI_WR: begin
                if (w_ack) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_bus_we_nxt = 1'b1;
                end
            end
            ST_SPI_RD: begin
                if (w_ack) begin
                    w_state_nxt     = ST_IDLE;
                    w_send_byte_nxt = iBUS_RDATA;
                end else begin
                    w_bus_re_nxt = 1'b1;
                end
            end
            ST_LOC: begin
                if (w_ack) begin
                    w_state_nxt    = ST_IDLE;
                    w_loc_gnt_nxt  = 1'b0;
                    w_loc_done_nxt = 1'b1;
                    if (!r_loc_we) begin
                        w_loc_rdata_nxt = iBUS_RDATA;
                    end
                end else begin
                    w_bus_we_nxt = r_loc_we;
                    w_bus_re_nxt = ~r_loc_we;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign oSPI_SEND_BYTE = r_send_byte;
    assign oSPI_ACTIVE    = r_active;
    assign oOVERRUN       = r_overrun;
    assign oLOC_GNT       = r_loc_gnt;
    assign oLOC_DONE      = r_loc_done;
    assign oLOC_RDATA     = r_loc_rdata;
    assign oBUS_SEL       = r_bus_sel;
    assign oBUS_ADDR      = r_bus_addr;
    assign oBUS_WE        = r_bus_we;
    assign oBUS_RE        = r_bus_re;
    assign oBUS_WDATA     = r_bus_wdata;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// Scoreboard bench for spi_bus_ctrl: directed SPI/local traffic against a register-file peripheral.
module tb_spi_bus_ctrl;

    localparam int unsigned AW = 3;
    localparam int P_WR = 0;
    localparam int P_RD = 1;
    localparam int P_IW = 2;
    localparam int P_IR = 3;
    localparam int C_GNT  = 0;
    localparam int C_DONE = 1;
    localparam int C_WE   = 2;
    localparam int C_IDLE = 3;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          iSPI_SS_n, iSPI_WRITE_SIG, iSPI_READ_SIG, iSPI_INC_WRADDR, iSPI_INC_RDADDR;
    logic [7:0]    iSPI_RCV_BYTE, iSPI_RCV_CMD;
    logic [7:0]    oSPI_SEND_BYTE;
    logic          oSPI_ACTIVE, oOVERRUN;
    logic          iLOC_REQ, iLOC_WE;
    logic [3:0]    iLOC_SEL;
    logic [AW-1:0] iLOC_ADDR;
    logic [7:0]    iLOC_WDATA;
    logic          oLOC_GNT, oLOC_DONE;
    logic [7:0]    oLOC_RDATA;
    logic [3:0]    oBUS_SEL;
    logic [AW-1:0] oBUS_ADDR;
    logic          oBUS_WE, oBUS_RE;
    logic [7:0]    oBUS_WDATA;
    logic [7:0]    iBUS_RDATA = 8'd0;
    logic          iBUS_ACK   = 1'b0;

    spi_bus_ctrl #(.ADDR_W(AW)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iSPI_SS_n(iSPI_SS_n), .iSPI_WRITE_SIG(iSPI_WRITE_SIG), .iSPI_READ_SIG(iSPI_READ_SIG),
        .iSPI_INC_WRADDR(iSPI_INC_WRADDR), .iSPI_INC_RDADDR(iSPI_INC_RDADDR),
        .iSPI_RCV_BYTE(iSPI_RCV_BYTE), .iSPI_RCV_CMD(iSPI_RCV_CMD),
        .oSPI_SEND_BYTE(oSPI_SEND_BYTE), .oSPI_ACTIVE(oSPI_ACTIVE), .oOVERRUN(oOVERRUN),
        .iLOC_REQ(iLOC_REQ), .iLOC_WE(iLOC_WE), .iLOC_SEL(iLOC_SEL), .iLOC_ADDR(iLOC_ADDR),
        .iLOC_WDATA(iLOC_WDATA), .oLOC_GNT(oLOC_GNT), .oLOC_DONE(oLOC_DONE), .oLOC_RDATA(oLOC_RDATA),
        .oBUS_SEL(oBUS_SEL), .oBUS_ADDR(oBUS_ADDR), .oBUS_WE(oBUS_WE), .oBUS_RE(oBUS_RE),
        .oBUS_WDATA(oBUS_WDATA), .iBUS_RDATA(iBUS_RDATA), .iBUS_ACK(iBUS_ACK)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic          we;
        logic [3:0]    sel;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
    } acc_t;

    acc_t       exp_q[$];
    acc_t       mon_got, mon_exp;
    int         checks = 0;
    int         errors = 0;
    int         ack_delay = 1;
    int         ack_cnt = 0;
    int         gnt_rises = 0;
    int         re_rises = 0;
    logic       prev_stb = 1'b0;
    logic       prev_gnt = 1'b0;
    logic       prev_re  = 1'b0;
    logic [7:0] mem [0:15][0:7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic we, input logic [3:0] sel, input logic [AW-1:0] addr,
                        input logic [7:0] wdata);
        acc_t e;
        e.we = we; e.sel = sel; e.addr = addr; e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    task automatic clk(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic pulse(input int which);
        case (which)
            P_WR:    iSPI_WRITE_SIG  = 1'b1;
            P_RD:    iSPI_READ_SIG   = 1'b1;
            P_IW:    iSPI_INC_WRADDR = 1'b1;
            default: iSPI_INC_RDADDR = 1'b1;
        endcase
        clk(4);
        iSPI_WRITE_SIG = 1'b0; iSPI_READ_SIG = 1'b0;
        iSPI_INC_WRADDR = 1'b0; iSPI_INC_RDADDR = 1'b0;
        clk(4);
    endtask

    function automatic logic cur(input int which);
        case (which)
            C_GNT:   return oLOC_GNT;
            C_DONE:  return oLOC_DONE;
            C_WE:    return oBUS_WE;
            default: return !(oBUS_WE || oBUS_RE);
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name);
        int n = 0;
        while (!cur(which) && n < budget) begin
            @(negedge iCLK);
            n++;
        end
        checks++;
        if (!cur(which)) begin
            errors++;
            $display("FAIL %s: condition still false after %0d cycles, required true", name, budget);
        end
    endtask

    task automatic spi_begin(input logic [7:0] cmd);
        iSPI_SS_n = 1'b0;
        clk(6);
        pulse(P_RD);
        iSPI_RCV_CMD = cmd;
        pulse(P_RD);
    endtask

    task automatic spi_wr_byte(input logic [7:0] d);
        iSPI_RCV_BYTE = d;
        pulse(P_WR);
        pulse(P_IW);
        pulse(P_RD);
    endtask

    task automatic spi_end();
        iSPI_SS_n = 1'b1;
        clk(8);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({oSPI_SEND_BYTE, oSPI_ACTIVE, oOVERRUN, oLOC_GNT, oLOC_DONE, oLOC_RDATA,
                    oBUS_SEL, oBUS_ADDR, oBUS_WE, oBUS_RE, oBUS_WDATA});
    endfunction

    // Peripheral: acks a held strobe after ack_delay cycles, register file behind it
    always @(negedge iCLK) begin
        if (iBUS_ACK) begin
            iBUS_ACK = 1'b0;
        end else if (oBUS_WE || oBUS_RE) begin
            if (ack_cnt >= ack_delay) begin
                iBUS_ACK = 1'b1;
                iBUS_RDATA = oBUS_RE ? mem[oBUS_SEL][oBUS_ADDR] : 8'h00;
                if (oBUS_WE) mem[oBUS_SEL][oBUS_ADDR] = oBUS_WDATA;
                ack_cnt = 0;
            end else begin
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    // Monitor: every new bus strobe is popped against the expected-access queue
    always @(negedge iCLK) begin
        if ((oBUS_WE || oBUS_RE) && !prev_stb) begin
            mon_got.we    = oBUS_WE;
            mon_got.sel   = oBUS_SEL;
            mon_got.addr  = oBUS_ADDR;
            mon_got.wdata = oBUS_WE ? oBUS_WDATA : 8'h00;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected: got we=%0d sel=%0d addr=%0d wdata=%02h, required no access",
                         mon_got.we, mon_got.sel, mon_got.addr, mon_got.wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL bus_access: got we=%0d sel=%0d addr=%0d wdata=%02h, required we=%0d sel=%0d addr=%0d wdata=%02h",
                             mon_got.we, mon_got.sel, mon_got.addr, mon_got.wdata,
                             mon_exp.we, mon_exp.sel, mon_exp.addr, mon_exp.wdata);
                end
            end
        end
        if (oLOC_GNT && !prev_gnt) gnt_rises++;
        if (oBUS_RE && !prev_re) re_rises++;
        prev_stb = oBUS_WE || oBUS_RE;
        prev_gnt = oLOC_GNT;
        prev_re  = oBUS_RE;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int r0;
        for (int s = 0; s < 16; s++)
            for (int a = 0; a < 8; a++)
                mem[s][a] = 8'h00;
        mem[3][5] = 8'hA5;
        mem[3][6] = 8'h5A;

        iRST = 1'b1;
        iSPI_SS_n = 1'b1; iSPI_WRITE_SIG = 1'b0; iSPI_READ_SIG = 1'b0;
        iSPI_INC_WRADDR = 1'b0; iSPI_INC_RDADDR = 1'b0;
        iSPI_RCV_BYTE = 8'h00; iSPI_RCV_CMD = 8'h00;
        iLOC_REQ = 1'b0; iLOC_WE = 1'b0; iLOC_SEL = 4'd0; iLOC_ADDR = '0; iLOC_WDATA = 8'h00;
        clk(3);
        check("reset_outputs", all_outs(), 64'd0);
        iRST = 1'b0;
        clk(4);
        check("idle_outputs", all_outs(), 64'd0);

        // SPI write: cmd 0x9A -> sel 3, addr 2 then 3
        ack_delay = 1;
        g0 = gnt_rises;
        push(1'b1, 4'd3, 3'd2, 8'h11);
        push(1'b1, 4'd3, 3'd3, 8'h22);
        spi_begin(8'h9A);
        check("spi_active", 64'(oSPI_ACTIVE), 64'd1);
        spi_wr_byte(8'h11);
        spi_wr_byte(8'h22);
        spi_end();
        check("spi_inactive", 64'(oSPI_ACTIVE), 64'd0);
        check("wr_no_local_gnt", 64'(gnt_rises - g0), 64'd0);
        check("wr_queue_empty", 64'(exp_q.size()), 64'd0);

        // SPI read: cmd 0x1D -> prefetch sel 3 addr 5, then addr 6
        push(1'b0, 4'd3, 3'd5, 8'h00);
        spi_begin(8'h1D);
        check("send_byte_1", 64'(oSPI_SEND_BYTE), 64'hA5);
        push(1'b0, 4'd3, 3'd6, 8'h00);
        pulse(P_IR);
        pulse(P_RD);
        check("send_byte_2", 64'(oSPI_SEND_BYTE), 64'h5A);
        spi_end();
        check("rd_queue_empty", 64'(exp_q.size()), 64'd0);

        // Arbitration: local read requested while an SPI write is already pending
        ack_delay = 2;
        g0 = gnt_rises;
        push(1'b1, 4'd4, 3'd1, 8'h77);
        push(1'b0, 4'd3, 3'd2, 8'h00);
        spi_begin(8'hA1);
        iSPI_RCV_BYTE = 8'h77;
        iSPI_WRITE_SIG = 1'b1;
        clk(3);
        iLOC_REQ = 1'b1; iLOC_WE = 1'b0; iLOC_SEL = 4'd3; iLOC_ADDR = 3'd2;
        clk(1);
        iSPI_WRITE_SIG = 1'b0;
        wait_for(C_GNT, 60, "loc_gnt");
        iLOC_REQ = 1'b0;
        wait_for(C_DONE, 60, "loc_done");
        check("loc_rdata", 64'(oLOC_RDATA), 64'h11);
        clk(1);
        check("loc_done_single", 64'(oLOC_DONE), 64'd0);
        clk(2);
        pulse(P_IW);
        pulse(P_RD);
        push(1'b1, 4'd4, 3'd2, 8'h88);
        spi_wr_byte(8'h88);
        spi_end();
        check("arb_one_grant", 64'(gnt_rises - g0), 64'd1);
        check("arb_queue_empty", 64'(exp_q.size()), 64'd0);

        // Address wrap: cmd 0x97 -> sel 2, addr 7 then 0
        ack_delay = 0;
        push(1'b1, 4'd2, 3'd7, 8'h33);
        push(1'b1, 4'd2, 3'd0, 8'h44);
        spi_begin(8'h97);
        spi_wr_byte(8'h33);
        spi_wr_byte(8'h44);
        spi_end();
        check("wrap_queue_empty", 64'(exp_q.size()), 64'd0);
        check("wrap_mem0", 64'(mem[2][0]), 64'h44);

        // Overrun: stalled ack, second write byte is dropped and flags overrun
        ack_delay = 40;
        push(1'b1, 4'd1, 3'd0, 8'hC3);
        spi_begin(8'h88);
        check("overrun_start", 64'(oOVERRUN), 64'd0);
        spi_wr_byte(8'hC3);
        spi_wr_byte(8'h3C);
        wait_for(C_IDLE, 100, "overrun_bus_idle");
        clk(4);
        check("overrun_set", 64'(oOVERRUN), 64'd1);
        check("overrun_kept_old", 64'(mem[1][0]), 64'hC3);
        spi_end();
        check("overrun_sticky", 64'(oOVERRUN), 64'd1);
        check("overrun_queue_empty", 64'(exp_q.size()), 64'd0);
        iSPI_SS_n = 1'b0;
        clk(6);
        check("overrun_cleared", 64'(oOVERRUN), 64'd0);
        spi_end();

        // Abort: read decoded while local write holds the bus, SS rises before it starts
        ack_delay = 60;
        r0 = re_rises;
        push(1'b1, 4'd5, 3'd4, 8'h9C);
        iSPI_SS_n = 1'b0;
        clk(6);
        pulse(P_RD);
        iSPI_RCV_CMD = 8'h1D;
        iLOC_REQ = 1'b1; iLOC_WE = 1'b1; iLOC_SEL = 4'd5; iLOC_ADDR = 3'd4; iLOC_WDATA = 8'h9C;
        wait_for(C_GNT, 20, "abort_loc_gnt");
        iLOC_REQ = 1'b0;
        pulse(P_RD);
        iSPI_SS_n = 1'b1;
        wait_for(C_DONE, 150, "abort_loc_done");
        clk(20);
        check("abort_no_read", 64'(re_rises - r0), 64'd0);
        check("abort_loc_write", 64'(mem[5][4]), 64'h9C);
        check("abort_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset during a stalled SPI write
        ack_delay = 40;
        push(1'b1, 4'd3, 3'd2, 8'h5E);
        spi_begin(8'h9A);
        iSPI_RCV_BYTE = 8'h5E;
        iSPI_WRITE_SIG = 1'b1;
        wait_for(C_WE, 20, "rst_write_started");
        iRST = 1'b1;
        clk(1);
        check("rst_mid_access", all_outs(), 64'd0);
        iRST = 1'b0;
        iSPI_WRITE_SIG = 1'b0;
        iSPI_SS_n = 1'b1;
        clk(10);
        check("rst_after_idle", 64'({oBUS_WE, oBUS_RE, oLOC_GNT}), 64'd0);
        check("rst_no_write", 64'(mem[3][2]), 64'h11);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_bus_ctrl.md
# spi_bus_ctrl

System-clock controller that sequences the SPI slave's byte datapath onto the shared peripheral register bus and arbitrates that bus against a local FPGA-logic requester. It synchronizes the SPI-domain strobes, decodes the command byte (write/read, peripheral select, start address), and maintains per-transaction write and read address counters. It performs bus writes for received bytes and prefetches read bytes into the slave's transmit byte.

## Interface
- ADDR_W, 8: register address width per peripheral.
- iCLK  in  1  system clock; one clock for the whole block, with fCLK ≥ 16×fSCK.
- iRST  in  1  synchronous, active-high reset.
- iSPI_SS_n, iSPI_WRITE_SIG, iSPI_READ_SIG, iSPI_INC_WRADDR, iSPI_INC_RDADDR  in  1 each  SPI-domain levels, asynchronous to iCLK.
- iSPI_RCV_BYTE, iSPI_RCV_CMD  in  8 each  SPI-domain data; sampled only on synchronized strobe edges.
- oSPI_SEND_BYTE  out  8  byte shifted out by the slave.
- oSPI_ACTIVE  out  1  synchronized, inverted SS.
- oOVERRUN  out  1  sticky SPI request overrun flag.
- iLOC_REQ  in  1  local access request.
- iLOC_WE  in  1  local write (1) or read (0).
- iLOC_SEL  in  4  local peripheral select.
- iLOC_ADDR  in  ADDR_W  local register address.
- iLOC_WDATA  in  8  local write data.
- oLOC_GNT  out  1  high while the local access owns the bus.
- oLOC_DONE  out  1  one-cycle completion pulse.
- oLOC_RDATA  out  8  local read data; valid with oLOC_DONE.
- oBUS_SEL  out  4  peripheral select.
- oBUS_ADDR  out  ADDR_W  register address.
- oBUS_WE, oBUS_RE  out  1 each  access strobes; held until ack.
- oBUS_WDATA  out  8  write data.
- iBUS_RDATA  in  8  read data.
- iBUS_ACK  in  1  access complete; one cycle.

## Operation
- Synchronizers: each SPI level passes through 2 flops plus 1 edge-detect flop. Only synchronized versions are used internally.
- SS falling edge (synced) starts a transaction:
  - clear the read-edge count, oOVERRUN, and the pending flags;
  - set oSPI_ACTIVE.
- Command decode happens on the 2nd READ_SIG rising edge of the transaction. This is the start of the first data byte, when iSPI_RCV_CMD is complete.
  - Capture dir = cmd[7], sel = cmd[6:3].
  - Set wr_addr = rd_addr = zero-extended cmd[2:0].
  - If dir = 0, set the rd_pend flag in the same cycle.
- Write path (dir = 1):
  - WRITE_SIG rising edge: capture iSPI_RCV_BYTE into the wdata register and set wr_pend.
  - INC_WRADDR rising edge: wr_addr += 1.
- Read path (dir = 0):
  - each READ_SIG rising edge after decode sets rd_pend;
  - INC_RDADDR rising edge: rd_addr += 1;
  - INC_WRADDR and WRITE_SIG are ignored while dir = 0.
- Overrun: a new request arriving while the same pending flag is still set sets oOVERRUN. The flag stays set; the old request is serviced and the new one is dropped.
- Arbiter FSM has states IDLE, SPI_WR, SPI_RD, LOC.
  - IDLE: priority order is wr_pend → SPI_WR, then rd_pend → SPI_RD, then iLOC_REQ → LOC.
  - SPI_WR drives oBUS_WE, sel, wr_addr and wdata until iBUS_ACK. Then it clears wr_pend and returns to IDLE.
  - SPI_RD drives oBUS_RE, sel and rd_addr until iBUS_ACK. On ack it loads oSPI_SEND_BYTE ← iBUS_RDATA, clears rd_pend and returns to IDLE.
  - LOC asserts oLOC_GNT and drives the iLOC_* fields until iBUS_ACK. On ack: pulse oLOC_DONE, set oLOC_RDATA ← iBUS_RDATA on reads, return to IDLE.
  - A local access is never preempted. SPI requests wait for it to finish.
- SS rising edge (synced):
  - clear oSPI_ACTIVE and drop wr_pend/rd_pend that have not started;
  - an access already on the bus completes normally.
- Address counters are ADDR_W bits and wrap from 2^ADDR_W−1 to 0 with no flag.

## Timing
- Reset values: FSM IDLE; every output 0, including oSPI_SEND_BYTE = 0x00 and oOVERRUN = 0. Counters and pending flags are cleared.
- Reset mid-access drops bus strobes on the next edge.
- Strobe-to-action latency is 3 iCLK cycles: synchronizer plus edge detect.
- Bus strobe asserts 1 cycle after the FSM leaves IDLE; it deasserts in the cycle after iBUS_ACK.
- IDLE re-arbitrates in the cycle after ack. No bubble is required beyond that one cycle.
- A read prefetch completes in at most 3 + 1 + ack-delay + 1 cycles. Peripherals ack SPI reads within 2 cycles, so this fits inside half an SCK period at fCLK ≥ 16×fSCK.
- Simultaneous events:
  - SS rising and a new request in the same cycle: SS wins and the request is dropped.
  - Decode and an INC edge in the same cycle: decode wins.

## Test plan
- Write: SS low, cmd 0x9A (write, sel 3, addr 2), data 0x11, 0x22. Expect bus writes sel 3 addr 2 = 0x11, then addr 3 = 0x22; no local grant.
- Read: cmd 0x1D (read, sel 3, addr 5); peripheral returns 0xA5 at 5 and 0x5A at 6. Expect oSPI_SEND_BYTE = 0xA5 before bit 7 of data byte 1 is sampled, then 0x5A for byte 2.
- Arbitration: iLOC_REQ held during SPI write traffic. Expect SPI writes serviced first; local granted in an idle gap; oLOC_DONE one pulse; oLOC_RDATA matches.
- Wrap and overrun: ADDR_W = 3, start addr 7, two data bytes. Expect addresses 7 then 0. Ack stalled for 40 cycles → expect oOVERRUN = 1, cleared at the next SS falling edge.
- Abort and reset: raise SS during a pending unstarted read → expect no bus read. Assert iRST mid-write → expect all outputs 0 on the next cycle and FSM IDLE.
